can_bit_destuffer: RTL
======================

Name: can_bit_destuffer

Overview:
- Sits between the bit-timing/sampling stage and can_receiver.
- Consumes raw sampled bus bits, tracks bus idle and SOF, and removes stuff bits from SOF through the end of the CRC sequence.
- Flags stuff-rule violations and presents only data bits to can_receiver as rx_point pulses, with current and previous destuffed bit values.
- After the CRC sequence, passes bits through unstuffed until end-of-frame idle is detected.

Parameters:
- STUFF_LEN, 5, run length of equal bits after which a complementary stuff bit is mandatory.
- IDLE_BITS, 11, consecutive recessive bits required for bus integration after reset or error.
- EOF_IDLE_BITS, 10, consecutive recessive bits in the unstuffed phase that end the frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sampled_bit  in  1  bus value at the current sample point (1 = recessive).
- sample_point  in  1  one-cycle strobe; sampled_bit is valid this cycle.
- stuff_stop  in  1  one-cycle pulse from can_receiver after it has taken the last CRC bit.
- rx_point  out  1  one-cycle strobe: rx_bit is a destuffed data bit.
- rx_bit  out  1  destuffed bit value.
- rx_bit_q  out  1  previous destuffed bit, i.e. the rx_bit value at the prior rx_point.
- sof_point  out  1  one-cycle strobe coincident with the rx_point of SOF.
- frame_active  out  1  high from SOF until return to IDLE or ERROR.
- bus_idle  out  1  high in the IDLE state.
- stuff_error  out  1  one-cycle pulse on a stuff violation.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered. Every output strobe appears exactly 1 clk after the sample_point cycle that caused it.
- Reset values: rx_point, sof_point, stuff_error, frame_active, bus_idle = 0; rx_bit, rx_bit_q = 1.
- Reset internal state: state = INTEGRATE, run_cnt = 0, last_bit = 1, rec_cnt = 0, expect_stuff = 0, stop_pending = 0.
- rst mid-frame aborts immediately: no strobe is produced and the block returns to INTEGRATE.
- States:
  - INTEGRATE: on each sample_point, rec_cnt++ if the bit is 1, else rec_cnt = 0. When rec_cnt reaches IDLE_BITS, go to IDLE. Dominant bits produce no output.
  - IDLE: bus_idle = 1. A recessive bit does nothing. A dominant bit is SOF: emit rx_point with rx_bit = 0, plus sof_point; set run_cnt = 1, last_bit = 0; go to STUFFED; frame_active = 1.
  - STUFFED, when expect_stuff = 1:
    - bit == last_bit: pulse stuff_error, no rx_point, go to ERROR.
    - bit != last_bit: drop the bit (no rx_point), set run_cnt = 1, last_bit = bit, expect_stuff = 0. If stop_pending = 1, go to UNSTUFFED and clear stop_pending.
  - STUFFED, when expect_stuff = 0:
    - Emit rx_point with the bit.
    - run_cnt = (bit == last_bit) ? run_cnt + 1 : 1; last_bit = bit.
    - When run_cnt becomes STUFF_LEN, set expect_stuff = 1.
    - run_cnt saturates; it never exceeds STUFF_LEN.
  - STUFFED, stuff_stop handling:
    - stuff_stop is evaluated after sample_point processing in the same cycle.
    - If expect_stuff = 1 at that point, set stop_pending: the trailing stuff bit is still checked and removed.
    - Otherwise go to UNSTUFFED at once.
  - UNSTUFFED: every sampled bit produces rx_point. rec_cnt counts consecutive recessive bits (starting at 0 on entry) and is reset by dominant. When rec_cnt reaches EOF_IDLE_BITS, go to IDLE; frame_active = 0 in the same registered update as the last rx_point.
  - ERROR: frame_active = 0, no rx_point. Count recessive bits as in INTEGRATE (starting at 0) and go to IDLE at IDLE_BITS.
- stuff_stop outside STUFFED is ignored.
- sample_point low: no state change except stuff_stop handling.
- rx_bit_q updates only on rx_point; stuff bits never affect rx_bit or rx_bit_q.

Test Plan:
- Reset, then 11 recessive bits -> bus_idle = 1 after the 11th (1 clk later). A dominant bit before the 11th produces no rx_point and restarts the count.
- From IDLE feed 0,0,0,0,0,1,0,1 -> 7 rx_points with bits 0,0,0,0,0,0,1; the 6th input (1) is dropped; sof_point on the first; stuff_error stays 0.
- From IDLE feed six consecutive 0s -> 5 rx_points, then stuff_error pulses once on the 6th bit with no rx_point; frame_active = 0; 11 recessive bits return bus_idle = 1.
- Mid-frame, send 1,1,1,1,1 with stuff_stop pulsed after the last rx_point, then feed 0,1,0 -> the 0 is dropped, then 1,0 are delivered as rx_points; then 6 consecutive 1s deliver 6 rx_points with no stuff_error.
- After stuff_stop, feed 1 (CRC delim), 0 (ACK), then ten 1s -> 12 rx_points; bus_idle = 1 after the 10th recessive. The next 0 gives sof_point.
- Assert rst for one cycle mid-STUFFED -> all outputs return to reset values next cycle; a following dominant bit is ignored until 11 recessive bits have passed.

Source files
------------

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: bus integration, SOF detection and stuff-bit removal up to the CRC end.
// Delivers only data bits to the receiver as registered rx_point strobes.
module can_bit_destuffer #(
  parameter int unsigned STUFF_LEN     = 5,
  parameter int unsigned IDLE_BITS     = 11,
  parameter int unsigned EOF_IDLE_BITS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic sampled_bit,
  input  logic sample_point,
  input  logic stuff_stop,
  output logic rx_point,
  output logic rx_bit,
  output logic rx_bit_q,
  output logic sof_point,
  output logic frame_active,
  output logic bus_idle,
  output logic stuff_error
);

  localparam int unsigned RecMax = (IDLE_BITS > EOF_IDLE_BITS) ? IDLE_BITS : EOF_IDLE_BITS;
  localparam int unsigned RecW   = $clog2(RecMax + 1);
  localparam int unsigned RunW   = $clog2(STUFF_LEN + 1);

  typedef enum logic [2:0] {
    StIntegrate,
    StIdle,
    StStuffed,
    StUnstuffed,
    StError
  } state_e;

  state_e          state_q, state_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic [RecW-1:0] rec_cnt_q, rec_cnt_d;
  logic            last_bit_q, last_bit_d;
  logic            expect_stuff_q, expect_stuff_d;
  logic            stop_pending_q, stop_pending_d;

  logic            rx_point_d, rx_bit_d, rx_prev_d;
  logic            sof_point_d, stuff_error_d, frame_active_d, bus_idle_d;

  logic [RecW-1:0] rec_inc;
  logic [RunW-1:0] run_inc;

  assign rec_inc = rec_cnt_q + RecW'(1);
  assign run_inc = (run_cnt_q == RunW'(STUFF_LEN)) ? run_cnt_q : run_cnt_q + RunW'(1);

  always_comb begin
    state_d        = state_q;
    run_cnt_d      = run_cnt_q;
    rec_cnt_d      = rec_cnt_q;
    last_bit_d     = last_bit_q;
    expect_stuff_d = expect_stuff_q;
    stop_pending_d = stop_pending_q;
    rx_point_d     = 1'b0;
    rx_bit_d       = rx_bit;
    sof_point_d    = 1'b0;
    stuff_error_d  = 1'b0;

    case (state_q)
      StIntegrate, StError: begin
        if (sample_point) begin
          if (!sampled_bit) begin
            rec_cnt_d = '0;
          end else if (rec_inc == RecW'(IDLE_BITS)) begin
            rec_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            rec_cnt_d = rec_inc;
          end
        end
      end

      StIdle: begin
        if (sample_point && !sampled_bit) begin
          rx_point_d     = 1'b1;
          rx_bit_d       = 1'b0;
          sof_point_d    = 1'b1;
          run_cnt_d      = RunW'(1);
          last_bit_d     = 1'b0;
          expect_stuff_d = 1'b0;
          stop_pending_d = 1'b0;
          state_d        = StStuffed;
        end
      end

      StStuffed: begin
        if (sample_point) begin
          if (expect_stuff_q) begin
            if (sampled_bit == last_bit_q) begin
              stuff_error_d  = 1'b1;
              expect_stuff_d = 1'b0;
              stop_pending_d = 1'b0;
              rec_cnt_d      = '0;
              state_d        = StError;
            end else begin
              // Valid stuff bit: consumed silently, restarts the run.
              run_cnt_d      = RunW'(1);
              last_bit_d     = sampled_bit;
              expect_stuff_d = 1'b0;
              if (stop_pending_q) begin
                stop_pending_d = 1'b0;
                rec_cnt_d      = '0;
                state_d        = StUnstuffed;
              end
            end
          end else begin
            rx_point_d     = 1'b1;
            rx_bit_d       = sampled_bit;
            last_bit_d     = sampled_bit;
            run_cnt_d      = (sampled_bit == last_bit_q) ? run_inc : RunW'(1);
            expect_stuff_d = (run_cnt_d == RunW'(STUFF_LEN));
          end
        end
        // stuff_stop sees the post-sample view; a pending stuff bit is still checked.
        if (stuff_stop && state_d == StStuffed) begin
          if (expect_stuff_d) begin
            stop_pending_d = 1'b1;
          end else begin
            rec_cnt_d = '0;
            state_d   = StUnstuffed;
          end
        end
      end

      StUnstuffed: begin
        if (sample_point) begin
          rx_point_d = 1'b1;
          rx_bit_d   = sampled_bit;
          if (!sampled_bit) begin
            rec_cnt_d = '0;
          end else if (rec_inc == RecW'(EOF_IDLE_BITS)) begin
            rec_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            rec_cnt_d = rec_inc;
          end
        end
      end

      default: begin
        rec_cnt_d = '0;
        state_d   = StIntegrate;
      end
    endcase

    rx_prev_d      = rx_point_d ? rx_bit : rx_bit_q;
    frame_active_d = (state_d == StStuffed) || (state_d == StUnstuffed);
    bus_idle_d     = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIntegrate;
      run_cnt_q      <= '0;
      rec_cnt_q      <= '0;
      last_bit_q     <= 1'b1;
      expect_stuff_q <= 1'b0;
      stop_pending_q <= 1'b0;
      rx_point       <= 1'b0;
      rx_bit         <= 1'b1;
      rx_bit_q       <= 1'b1;
      sof_point      <= 1'b0;
      stuff_error    <= 1'b0;
      frame_active   <= 1'b0;
      bus_idle       <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_cnt_q      <= run_cnt_d;
      rec_cnt_q      <= rec_cnt_d;
      last_bit_q     <= last_bit_d;
      expect_stuff_q <= expect_stuff_d;
      stop_pending_q <= stop_pending_d;
      rx_point       <= rx_point_d;
      rx_bit         <= rx_bit_d;
      rx_bit_q       <= rx_prev_d;
      sof_point      <= sof_point_d;
      stuff_error    <= stuff_error_d;
      frame_active   <= frame_active_d;
      bus_idle       <= bus_idle_d;
    end
  end

endmodule
